// File: rtl/sht3x_pkg.sv
// Shared types and constants for the SHT3x measurement frame decoder.
// Covers CRC-8 parameters, fixed-point scale factors and frame geometry.
package sht3x_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StCheck,
    StConvert,
    StDone
  } state_e;

  localparam logic [7:0]  CrcPoly    = 8'h31;
  localparam logic [7:0]  CrcInit    = 8'hFF;

  localparam logic [26:0] TempScale  = 27'd1750;
  localparam logic [26:0] HumScale   = 27'd1000;
  localparam logic [11:0] TempOffset = 12'd450;
  localparam logic [26:0] RoundConst = 27'd32768;

  localparam int unsigned FrameLen   = 6;
  localparam logic [2:0]  LastIdx    = 3'(FrameLen - 1);

endpackage

// File: rtl/sht3x_crc8.sv
// Combinational single-byte CRC-8 update (MSB first, no reflection, no final XOR).
module sht3x_crc8
  import sht3x_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CrcPoly) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sht3x_frame_decoder.sv
// Collects a 6-byte SHT3x measurement frame, checks both word CRCs and converts
// the raw words to 0.1 degC / 0.1 %RH fixed-point results.
module sht3x_frame_decoder
  import sht3x_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [7:0]         rx_byte,
  input  logic               rx_byte_valid,
  input  logic               abort,
  output logic signed [11:0] temp_dc,
  output logic [9:0]         hum_dpm,
  output logic               meas_valid,
  output logic               crc_error,
  output logic [1:0]         crc_fail_mask,
  output logic               busy
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] raw_t_q, raw_t_d, raw_h_q, raw_h_d;
  logic [7:0]  rx_crc_t_q, rx_crc_t_d, rx_crc_h_q, rx_crc_h_d;
  logic [7:0]  crc_t_q, crc_t_d, crc_h_q, crc_h_d;
  logic [1:0]  fail_q, fail_d;
  logic [26:0] prod_t_q, prod_t_d, prod_h_q, prod_h_d;
  logic [11:0] temp_q, temp_d;
  logic [9:0]  hum_q, hum_d;
  logic        mv_q, mv_d, ce_q, ce_d;
  logic [1:0]  mask_q, mask_d;

  logic [7:0]  crc_in, crc_out;
  logic [26:0] t_round, h_round;

  // Bytes 0..2 belong to the temperature word, 3..5 to humidity.
  assign crc_in = (idx_q < 3'd3) ? crc_t_q : crc_h_q;

  sht3x_crc8 u_crc8 (
    .crc_in  (crc_in),
    .data    (rx_byte),
    .crc_out (crc_out)
  );

  assign t_round = prod_t_q + RoundConst;
  assign h_round = prod_h_q + RoundConst;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    raw_t_d    = raw_t_q;
    raw_h_d    = raw_h_q;
    rx_crc_t_d = rx_crc_t_q;
    rx_crc_h_d = rx_crc_h_q;
    crc_t_d    = crc_t_q;
    crc_h_d    = crc_h_q;
    fail_d     = fail_q;
    prod_t_d   = prod_t_q;
    prod_h_d   = prod_h_q;
    temp_d     = temp_q;
    hum_d      = hum_q;
    mask_d     = mask_q;
    mv_d       = 1'b0;
    ce_d       = 1'b0;

    if (abort) begin
      state_d = StIdle;
      idx_d   = 3'd0;
    end else if (frame_start) begin
      state_d = StCollect;
      idx_d   = 3'd0;
      crc_t_d = CrcInit;
      crc_h_d = CrcInit;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCollect: begin
          if (rx_byte_valid) begin
            idx_d = idx_q + 3'd1;
            unique case (idx_q)
              3'd0: begin raw_t_d[15:8] = rx_byte; crc_t_d = crc_out; end
              3'd1: begin raw_t_d[7:0]  = rx_byte; crc_t_d = crc_out; end
              3'd2: rx_crc_t_d = rx_byte;
              3'd3: begin raw_h_d[15:8] = rx_byte; crc_h_d = crc_out; end
              3'd4: begin raw_h_d[7:0]  = rx_byte; crc_h_d = crc_out; end
              default: rx_crc_h_d = rx_byte;
            endcase
            if (idx_q == LastIdx) state_d = StCheck;
          end
        end
        StCheck: begin
          fail_d  = {crc_h_q != rx_crc_h_q, crc_t_q != rx_crc_t_q};
          state_d = StConvert;
        end
        StConvert: begin
          prod_t_d = 27'(raw_t_q) * TempScale;
          prod_h_d = 27'(raw_h_q) * HumScale;
          state_d  = StDone;
        end
        StDone: begin
          mask_d = fail_q;
          if (fail_q == 2'b00) begin
            mv_d   = 1'b1;
            temp_d = {1'b0, 11'(t_round >> 16)} - TempOffset;
            hum_d  = 10'(h_round >> 16);
          end else begin
            ce_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      raw_t_q    <= 16'd0;
      raw_h_q    <= 16'd0;
      rx_crc_t_q <= 8'd0;
      rx_crc_h_q <= 8'd0;
      crc_t_q    <= CrcInit;
      crc_h_q    <= CrcInit;
      fail_q     <= 2'b00;
      prod_t_q   <= 27'd0;
      prod_h_q   <= 27'd0;
      temp_q     <= 12'd0;
      hum_q      <= 10'd0;
      mv_q       <= 1'b0;
      ce_q       <= 1'b0;
      mask_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      raw_t_q    <= raw_t_d;
      raw_h_q    <= raw_h_d;
      rx_crc_t_q <= rx_crc_t_d;
      rx_crc_h_q <= rx_crc_h_d;
      crc_t_q    <= crc_t_d;
      crc_h_q    <= crc_h_d;
      fail_q     <= fail_d;
      prod_t_q   <= prod_t_d;
      prod_h_q   <= prod_h_d;
      temp_q     <= temp_d;
      hum_q      <= hum_d;
      mv_q       <= mv_d;
      ce_q       <= ce_d;
      mask_q     <= mask_d;
    end
  end

  assign temp_dc       = temp_q;
  assign hum_dpm       = hum_q;
  assign meas_valid    = mv_q;
  assign crc_error     = ce_q;
  assign crc_fail_mask = mask_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sht3x_frame_decoder.sv
// Directed bench for sht3x_frame_decoder: vector table of whole frames plus
// hand-written abort, restart, reset and collision sequences.
module tb_sht3x_frame_decoder;

  logic               clk;
  logic               rst_n;
  logic               frame_start;
  logic [7:0]         rx_byte;
  logic               rx_byte_valid;
  logic               abort;
  logic signed [11:0] temp_dc;
  logic [9:0]         hum_dpm;
  logic               meas_valid;
  logic               crc_error;
  logic [1:0]         crc_fail_mask;
  logic               busy;

  int tests = 0;
  int fails = 0;

  sht3x_frame_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .abort         (abort),
    .temp_dc       (temp_dc),
    .hum_dpm       (hum_dpm),
    .meas_valid    (meas_valid),
    .crc_error     (crc_error),
    .crc_fail_mask (crc_fail_mask),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] frame;
    logic        exp_ok;
    logic [1:0]  exp_mask;
    int          exp_t;
    int          exp_h;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [47:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_byte       = f[47 - 8*i -: 8];
      rx_byte_valid = 1'b1;
      tick();
    end
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    send_bytes(f, n);
  endtask

  task automatic wait_verdict(output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (meas_valid || crc_error) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int nmv, output int nce, output int nboth);
    nmv = 0; nce = 0; nboth = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (meas_valid) nmv++;
      if (crc_error) nce++;
      if (meas_valid && crc_error) nboth++;
    end
  endtask

  localparam logic [47:0] GoodA = 48'hBEEF92_666693;
  localparam logic [47:0] GoodB = 48'h000081_FFFFAC;

  initial begin
    int lat, nmv, nce, nboth;
    int last_t, last_h;

    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nmv, nce, nboth;
    int last_t, last_h;

    vecs[0] = '{GoodA,                 1'b1, 2'b00,  855,  400};
    vecs[1] = '{GoodB,                 1'b1, 2'b00, -450, 1000};
    vecs[2] = '{48'hFFFFAC_000081,     1'b1, 2'b00, 1300,    0};
    vecs[3] = '{48'hBEEF93_666693,     1'b0, 2'b01,    0,    0};
    vecs[4] = '{48'hBEEF92_666694,     1'b0, 2'b10,    0,    0};
    vecs[5] = '{48'h000000_000000,     1'b0, 2'b11,    0,    0};
    vecs[6] = '{GoodA,                 1'b1, 2'b00,  855,  400};

    rst_n = 1'b0; frame_start = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0; abort = 1'b0;
    tick(); tick();
    check("rst_temp", temp_dc, 0);
    check("rst_hum", hum_dpm, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_err", crc_error, 0);
    check("rst_mask", crc_fail_mask, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Bytes before any frame_start must be ignored.
    send_bytes(GoodA, 6);
    count_pulses(6, nmv, nce, nboth);
    check("idle_bytes_pulses", nmv + nce, 0);
    check("idle_bytes_busy", busy, 0);

    last_t = 0; last_h = 0;
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].frame, 6);
      check($sformatf("v%0d_busy_mid", i), busy, 1);
      wait_verdict(lat);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_meas_valid", i), meas_valid, vecs[i].exp_ok);
      check($sformatf("v%0d_crc_error", i), crc_error, !vecs[i].exp_ok);
      if (vecs[i].exp_ok) begin
        last_t = vecs[i].exp_t;
        last_h = vecs[i].exp_h;
      end else begin
        check($sformatf("v%0d_mask", i), crc_fail_mask, vecs[i].exp_mask);
      end
      check($sformatf("v%0d_temp", i), temp_dc, last_t);
      check($sformatf("v%0d_hum", i), hum_dpm, last_h);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      tick();
      check($sformatf("v%0d_pulse_width", i), meas_valid | crc_error, 0);
    end

    // Abort after three bytes, then a clean frame.
    send_frame(GoodB, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    count_pulses(8, nmv, nce, nboth);
    check("abort_no_pulse", nmv + nce, 0);
    check("abort_temp_hold", temp_dc, 855);
    send_frame(GoodB, 6);
    count_pulses(6, nmv, nce, nboth);
    check("after_abort_valid", nmv, 1);
    check("after_abort_err", nce, 0);
    check("after_abort_temp", temp_dc, -450);
    check("after_abort_hum", hum_dpm, 1000);

    // Restart after four bytes, full frame, then a stray seventh byte.
    send_frame(GoodB, 4);
    send_frame(GoodA, 6);
    rx_byte = 8'h5A;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    count_pulses(10, nmv, nce, nboth);
    check("restart_valid_count", nmv, 1);
    check("restart_err_count", nce, 0);
    check("restart_both", nboth, 0);
    check("restart_temp", temp_dc, 855);
    check("restart_hum", hum_dpm, 400);

    // Reset mid-frame clears outputs at once and drops the partial frame.
    send_frame(GoodA, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_temp", temp_dc, 0);
    check("midrst_hum", hum_dpm, 0);
    check("midrst_busy", busy, 0);
    tick(); tick();
    rst_n = 1'b1;
    send_bytes(48'h666693_000000, 3);
    count_pulses(8, nmv, nce, nboth);
    check("midrst_no_pulse", nmv + nce, 0);
    check("midrst_busy_after", busy, 0);

    // frame_start with a simultaneous byte: the byte is dropped.
    frame_start = 1'b1;
    rx_byte = 8'hAA;
    rx_byte_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    rx_byte_valid = 1'b0;
    send_bytes(GoodA, 6);
    wait_verdict(lat);
    check("collide_latency", lat, 3);
    check("collide_valid", meas_valid, 1);
    check("collide_temp", temp_dc, 855);
    check("collide_hum", hum_dpm, 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sht3x_frame_decoder.md
SHT3X_FRAME_DECODER -- requirements
Module: sht3x_frame_decoder

Interface
REQ-001 Clocking and reset SHALL be one clock and one asynchronous, active-low reset: ports clk and rst_n.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 frame_start  input  1  one-cycle pulse; arms decoder for a new 6-byte frame.
REQ-005 rx_byte  input  8  received byte from I2C master read_data.
REQ-006 rx_byte_valid  input  1  one-cycle strobe qualifying rx_byte (I2C master rx_data_ready).
REQ-007 abort  input  1  transfer failed (I2C master tranfer_failed); discards the frame in progress.
REQ-008 temp_dc  output  12 signed  temperature in 0.1 degC, range -450..1300.
REQ-009 hum_dpm  output  10  relative humidity in 0.1 %RH, range 0..1000.
REQ-010 meas_valid  output  1  one-cycle pulse: temp_dc/hum_dpm just updated.
REQ-011 crc_error  output  1  one-cycle pulse: frame rejected.
REQ-012 crc_fail_mask  output  2  bit0 = temperature word failed, bit1 = humidity word failed; valid with crc_error, held until next verdict.
REQ-013 busy  output  1  high from frame_start until the verdict cycle ends.

Function
REQ-014 Frame byte order SHALL be T_MSB, T_LSB, T_CRC, H_MSB, H_LSB, H_CRC.
REQ-015 States SHALL be IDLE, COLLECT, CHECK, CONVERT, DONE.
REQ-016 IDLE -> COLLECT on frame_start; rx_byte_valid in IDLE ignored.
REQ-017 COLLECT: each rx_byte_valid stores rx_byte at byte index 0..5; index increments by 1; 6th byte -> CHECK.
REQ-018 CRC SHALL be CRC-8, polynomial 0x31, init 0xFF, no reflection, no final XOR, over each 2-byte word; computed byte-at-a-time as bytes arrive.
REQ-019 CHECK (1 cycle): compare each computed CRC with received CRC byte; -> CONVERT.
REQ-020 CONVERT (1 cycle): register products raw_t*1750 and raw_h*1000 (27 bits unsigned); -> DONE.
REQ-021 DONE (1 cycle): if both CRCs match, temp_dc = ((raw_t*1750 + 32768) >> 16) - 450 and hum_dpm = (raw_h*1000 + 32768) >> 16, meas_valid = 1; otherwise crc_error = 1 and crc_fail_mask updated, temp_dc/hum_dpm hold; -> IDLE.
REQ-022 Latency: meas_valid/crc_error SHALL assert on the 3rd rising edge after the edge that captured byte 6.
REQ-023 Scaling SHALL use >>16 (divide by 65536, not 65535); no clamping is needed at raw 0x0000/0xFFFF.
REQ-024 frame_start in any non-IDLE state SHALL restart COLLECT at index 0 with CRCs re-initialised; no verdict pulse for the dropped frame.
REQ-025 frame_start and rx_byte_valid in the same cycle: frame_start wins, byte discarded.
REQ-026 abort in any state: -> IDLE next edge, no verdict pulse, busy low, outputs hold; abort outranks frame_start.
REQ-027 rx_byte_valid in CHECK/CONVERT/DONE SHALL be ignored.
REQ-028 meas_valid and crc_error SHALL never both be high.

Reset
REQ-029 On rst_n low: state IDLE, byte index 0, temp_dc 0, hum_dpm 0, meas_valid 0, crc_error 0, crc_fail_mask 0, busy 0.
REQ-030 Reset mid-frame SHALL discard all captured bytes; first frame after release needs a fresh frame_start.

Structure
REQ-031 Package sht3x_pkg SHALL hold the state enum, CRC poly/init constants, scale constants (1750, 1000, 450, rounding 32768), and the frame length (6).
REQ-032 Sub-module sht3x_crc8 SHALL implement the combinational one-byte CRC update (crc_in, data -> crc_out); instantiated once and shared by both words.

Verification
REQ-033 Bytes BE EF 92 66 66 93 -> meas_valid, temp_dc 855, hum_dpm 400, 3 edges after the 6th byte.
REQ-034 Bytes 00 00 81 FF FF AC -> temp_dc -450, hum_dpm 1000, meas_valid.
REQ-035 Bytes BE EF 93 66 66 93 -> crc_error, crc_fail_mask 01, temp_dc/hum_dpm unchanged.
REQ-036 abort after 3 bytes -> no pulse, busy low next cycle; following good frame decodes correctly.
REQ-037 frame_start after 4 bytes, then a full good frame plus a 7th stray byte -> exactly one meas_valid; stray byte ignored.
REQ-038 rst_n asserted mid-frame -> all outputs 0 immediately; no pulse after release.
